// File: rtl/correlation_stream.sv
`default_nettype none
// ============================================================================
// Module   : correlation_stream
// Purpose  : Streams NUM candidate words past a latched target and reports the
//            index/score of the candidate with the most (or fewest) agreeing bits.
// Revision : 1.0 - initial streaming release
// ============================================================================
module correlation_stream #(
    parameter int WIDTH = 32,
    parameter int NUM   = 16,
    parameter int IDX_W = $clog2(NUM),
    parameter int SC_W  = $clog2(WIDTH + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Target_Num,
    input  logic             In_Valid,
    input  logic [WIDTH-1:0] In_Num,
    output logic             In_Ready,
    output logic             Busy,
    output logic             Out_Valid,
    output logic [IDX_W-1:0] Out_Index,
    output logic [SC_W-1:0]  Out_Score
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_target;
    logic             r_mode;
    logic [IDX_W-1:0] r_cnt;
    logic             r_s1_valid;
    logic [SC_W-1:0]  r_s1_score;
    logic [IDX_W-1:0] r_s1_idx;
    logic             r_best_valid;

    logic [WIDTH-1:0] w_agree;
    logic [SC_W-1:0]  w_score;
    logic             w_accept;
    logic             w_last;
    logic             w_better;
    logic             w_commit;

    assign In_Ready  = (r_state == S_RUN);
    assign Busy      = (r_state != S_IDLE);
    assign Out_Valid = (r_state == S_DONE);

    assign w_accept = In_Valid & In_Ready;
    assign w_last   = (r_cnt == c_last_idx);
    assign w_agree  = ~(In_Num ^ r_target);

    always_comb begin
        w_score = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_score = w_score + SC_W'(w_agree[i]);
        end
    end

    // Strict comparison keeps the earliest candidate on ties in both modes.
    assign w_better = r_mode ? (r_s1_score < Out_Score) : (r_s1_score > Out_Score);
    assign w_commit = r_s1_valid & (~r_best_valid | w_better);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_next_state = S_RUN;
            S_RUN:   if (w_accept && w_last) w_next_state = S_FLUSH;
            S_FLUSH: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state      <= S_IDLE;
            r_target     <= '0;
            r_mode       <= 1'b0;
            r_cnt        <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_score   <= '0;
            r_s1_idx     <= '0;
            r_best_valid <= 1'b0;
            Out_Index    <= '0;
            Out_Score    <= '0;
        end else begin
            r_state    <= w_next_state;
            r_s1_valid <= w_accept;

            if (r_state == S_IDLE && Start) begin
                r_target     <= Target_Num;
                r_mode       <= Mode;
                r_cnt        <= '0;
                r_best_valid <= 1'b0;
            end

            if (w_accept) begin
                r_s1_score <= w_score;
                r_s1_idx   <= r_cnt;
                if (!w_last) begin
                    r_cnt <= r_cnt + IDX_W'(1);
                end
            end

            // The result registers double as the running best.
            if (w_commit) begin
                Out_Score    <= r_s1_score;
                Out_Index    <= r_s1_idx;
                r_best_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_correlation_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_correlation_stream
// Purpose  : Directed scoreboard bench for correlation_stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_correlation_stream;

    localparam int WIDTH = 32;
    localparam int NUM   = 16;
    localparam int IDX_W = $clog2(NUM);
    localparam int SC_W  = $clog2(WIDTH + 1);

    logic             Clock      = 1'b0;
    logic             Reset      = 1'b0;
    logic             Start      = 1'b0;
    logic             Mode       = 1'b0;
    logic [WIDTH-1:0] Target_Num = '0;
    logic             In_Valid   = 1'b0;
    logic [WIDTH-1:0] In_Num     = '0;
    logic             In_Ready;
    logic             Busy;
    logic             Out_Valid;
    logic [IDX_W-1:0] Out_Index;
    logic [SC_W-1:0]  Out_Score;

    correlation_stream #(
        .WIDTH(WIDTH),
        .NUM  (NUM)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Mode      (Mode),
        .Target_Num(Target_Num),
        .In_Valid  (In_Valid),
        .In_Num    (In_Num),
        .In_Ready  (In_Ready),
        .Busy      (Busy),
        .Out_Valid (Out_Valid),
        .Out_Index (Out_Index),
        .Out_Score (Out_Score)
    );

    always #5 Clock = ~Clock;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;

    logic [WIDTH-1:0]       cands [NUM];
    logic [IDX_W+SC_W-1:0]  sb [$];

    always @(negedge Clock) begin
        if (Out_Valid === 1'b1) pulses++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [SC_W-1:0] agree(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int s = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i] == b[i]) s++;
        end
        return SC_W'(s);
    endfunction

    task automatic push_expected(input logic [WIDTH-1:0] tgt, input logic md);
        logic [IDX_W-1:0] bi = '0;
        logic [SC_W-1:0]  bs = '0;
        logic [SC_W-1:0]  sc;
        for (int k = 0; k < NUM; k++) begin
            sc = agree(cands[k], tgt);
            if (k == 0 || (md ? (sc < bs) : (sc > bs))) begin
                bi = IDX_W'(k);
                bs = sc;
            end
        end
        sb.push_back({bi, bs});
    endtask

    task automatic run_search(input string tag, input logic [WIDTH-1:0] tgt, input logic md,
                              input int gap, input bit hold, input int glitch_at);
        int p0;
        int lat;
        bit rdy_ok;
        logic [IDX_W+SC_W-1:0] e;
        push_expected(tgt, md);
        p0 = pulses;
        Start = 1'b1; Mode = md; Target_Num = tgt;
        step();
        Start = 1'b0; Mode = ~md; Target_Num = ~tgt;
        rdy_ok = 1'b1;
        for (int k = 0; k < NUM; k++) begin
            In_Valid = 1'b1;
            In_Num   = cands[k];
            if (k == glitch_at) begin
                Start = 1'b1;
                Target_Num = '1;
            end
            if (In_Ready !== 1'b1) rdy_ok = 1'b0;
            step();
            Start = 1'b0;
            if (k < NUM - 1) begin
                In_Valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    if (In_Ready !== 1'b1) rdy_ok = 1'b0;
                    step();
                end
            end
        end
        if (hold) begin
            In_Valid = 1'b1;
            In_Num   = tgt;
        end else begin
            In_Valid = 1'b0;
        end
        chk({tag, " ready_in_run"}, 64'(rdy_ok), 64'd1);
        chk({tag, " ready_after_last"}, 64'(In_Ready), 64'd0);
        lat = 1;
        while (Out_Valid !== 1'b1 && lat < 8) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'd2);
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 64'd1, 64'd0);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        chk({tag, " index"}, 64'(Out_Index), 64'(e[IDX_W+SC_W-1:SC_W]));
        chk({tag, " score"}, 64'(Out_Score), 64'(e[SC_W-1:0]));
        step();
        chk({tag, " valid_drop"}, 64'(Out_Valid), 64'd0);
        chk({tag, " busy_drop"}, 64'(Busy), 64'd0);
        if (hold) begin
            repeat (3) begin
                chk({tag, " ready_idle"}, 64'(In_Ready), 64'd0);
                step();
            end
        end
        In_Valid = 1'b0;
        chk({tag, " pulses"}, 64'(pulses - p0), 64'd1);
        chk({tag, " index_hold"}, 64'(Out_Index), 64'(e[IDX_W+SC_W-1:SC_W]));
    endtask

    task automatic load_exact();
        for (int k = 0; k < NUM; k++) cands[k] = 32'd1;
        cands[2] = 32'd0;
        cands[8] = 32'd0;
    endtask

    initial begin
        int p0;
        Reset = 1'b0;
        repeat (2) step();
        chk("reset in_ready", 64'(In_Ready), 64'd0);
        chk("reset busy", 64'(Busy), 64'd0);
        chk("reset out_valid", 64'(Out_Valid), 64'd0);
        chk("reset out_index", 64'(Out_Index), 64'd0);
        chk("reset out_score", 64'(Out_Score), 64'd0);
        Reset = 1'b1;
        step();

        load_exact();
        run_search("exact", 32'h0, 1'b0, 0, 1'b0, -1);

        for (int k = 0; k < NUM; k++) cands[k] = 32'h0;
        cands[5] = 32'hFFFF_FFFF;
        run_search("min", 32'h0, 1'b1, 0, 1'b0, -1);

        for (int k = 0; k < NUM; k++) cands[k] = 32'hA5A5_A5A5;
        run_search("tie_max", 32'h0F0F_0F0F, 1'b0, 0, 1'b0, -1);
        run_search("tie_min", 32'h0F0F_0F0F, 1'b1, 0, 1'b0, -1);

        load_exact();
        run_search("gaps", 32'h0, 1'b0, 3, 1'b1, -1);

        // Abandon a search after beat 7 with a one-cycle reset.
        p0 = pulses;
        Start = 1'b1; Mode = 1'b0; Target_Num = 32'h0;
        step();
        Start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            In_Valid = 1'b1;
            In_Num   = cands[k];
            step();
        end
        In_Valid = 1'b0;
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        chk("midreset in_ready", 64'(In_Ready), 64'd0);
        chk("midreset busy", 64'(Busy), 64'd0);
        chk("midreset out_valid", 64'(Out_Valid), 64'd0);
        chk("midreset out_index", 64'(Out_Index), 64'd0);
        chk("midreset out_score", 64'(Out_Score), 64'd0);
        repeat (4) step();
        chk("midreset no_pulse", 64'(pulses - p0), 64'd0);
        run_search("after_reset", 32'h0, 1'b0, 0, 1'b0, -1);

        run_search("start_busy", 32'h0, 1'b0, 1, 1'b0, 4);

        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
